instr_sequencer: RTL

Multi-cycle control FSM for the RV32I datapath. Fetches an instruction word, holds it in an instruction register driving the instruction control decoder, then steps EXEC/MEM/WB from the decoder's should_* flags. Issues instruction-memory and data-memory handshakes, PC update and register write strobes. Traps on illegal opcodes or memory timeouts.

---
 rtl/instr_sequencer_if.sv | 56 +++++
 rtl/instr_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
//   Groups every handshake, decoder and strobe signal of the RV32I multi-cycle
//   sequencer. clk and reset stay plain ports on the sequencer.
//
//   master : the sequencer (drives requests, strobes, instr, trap, counters)
//   slave  : the surrounding datapath / memories / decoder
//
//   Signals
//     imem_req/imem_ack/imem_rdata : instruction fetch handshake
//     instr                        : instruction register, feeds the decoder
//     dec_*                        : decoder should_* flags
//     branch_taken                 : comparator result, used in WB
//     dmem_req/dmem_we/dmem_ack    : data access handshake
//     reg_we, wb_sel               : register file write strobe and source
//     pc_we, pc_sel                : PC write strobe and source
//     trap, trap_cause             : sticky halt flag and its reason
//     cycle_count, instret_count   : optional performance counters
// ---------------------------------------------------------------------------
interface instr_sequencer_if;
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        dec_read_mem;
  logic        dec_write_mem;
  logic        dec_write_reg;
  logic        dec_branch;
  logic        dec_jump;
  logic        branch_taken;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic        pc_we;
  logic [1:0]  pc_sel;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [63:0] cycle_count;
  logic [63:0] instret_count;

  modport master (
    output imem_req, instr, dmem_req, dmem_we, reg_we, wb_sel, pc_we, pc_sel,
           trap, trap_cause, cycle_count, instret_count,
    input  imem_ack, imem_rdata, dec_read_mem, dec_write_mem, dec_write_reg,
           dec_branch, dec_jump, branch_taken, dmem_ack
  );

  modport slave (
    input  imem_req, instr, dmem_req, dmem_we, reg_we, wb_sel, pc_we, pc_sel,
           trap, trap_cause, cycle_count, instret_count,
    output imem_ack, imem_rdata, dec_read_mem, dec_write_mem, dec_write_reg,
           dec_branch, dec_jump, branch_taken, dmem_ack
  );
endinterface

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Multi-cycle control FSM for the RV32I datapath:
//   INIT -> FETCH -> DECODE -> EXEC -> [MEM] -> WB -> FETCH ...
//   Illegal opcodes and memory handshakes that exceed TIMEOUT_CYCLES waiting
//   cycles send the FSM to TRAP, which only reset leaves.
//
//   Parameters
//     TIMEOUT_CYCLES : waiting cycles allowed for imem_ack/dmem_ack (0 = never)
//     RESET_PC_SEL   : pc_sel driven with pc_we in the INIT cycle
//
//   Ports
//     clk   : clock, rising edge
//     reset : asynchronous, active-high reset
//     bus   : instr_sequencer_if.master (handshakes, strobes, decoder flags)
//
//   Optional feature macro: SEQ_PERF_COUNTERS_EN
//     defined   -> 64-bit cycle_count / instret_count counters
//     undefined -> both counter outputs tied to 0
// ---------------------------------------------------------------------------
module instr_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [1:0]  RESET_PC_SEL   = 2'b11
) (
  input  logic               clk,
  input  logic               reset,
  instr_sequencer_if.master  bus
);

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] TMO_LIMIT = 32'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_INIT,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_instr;
  logic [31:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic        r_dmem_we, w_dmem_we_nxt;
  logic [1:0]  r_trap_cause, w_trap_cause_nxt;
  logic        w_instr_load;
  logic [31:0] w_tmo_inc;
  logic        w_tmo_hit;
  logic        w_legal;

  // Legal RV32I major opcodes: LOAD, MISC-MEM, OP-IMM, AUIPC, STORE, OP, LUI,
  // BRANCH, JALR, JAL.
  function automatic logic opcode_legal(input logic [31:0] i);
    logic ok;
    case (i[6:2])
      5'h00, 5'h03, 5'h04, 5'h05, 5'h08,
      5'h0C, 5'h0D, 5'h18, 5'h19, 5'h1B: ok = (i[1:0] == 2'b11);
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign w_legal   = opcode_legal(r_instr);
  assign w_tmo_inc = r_tmo_cnt + 32'd1;
  // The cycle that would bring the wait count up to the limit traps, unless
  // the ack arrives in that same cycle (ack is tested first below).
  assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (w_tmo_inc == TMO_LIMIT);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt      = r_state;
    w_tmo_cnt_nxt    = r_tmo_cnt;
    w_dmem_we_nxt    = r_dmem_we;
    w_trap_cause_nxt = r_trap_cause;
    w_instr_load     = 1'b0;
    bus.imem_req     = 1'b0;
    bus.dmem_req     = 1'b0;
    bus.dmem_we      = 1'b0;
    bus.reg_we       = 1'b0;
    bus.wb_sel       = 2'b00;
    bus.pc_we        = 1'b0;
    bus.pc_sel       = 2'b00;
    bus.trap         = 1'b0;

    case (r_state)
      S_INIT: begin
        // INIT is also the state held during reset; the vector load only
        // fires in the first cycle after reset is released.
        if (!reset) begin
          bus.pc_we  = 1'b1;
          bus.pc_sel = RESET_PC_SEL;
        end
        w_tmo_cnt_nxt = 32'd0;
        w_state_nxt   = S_FETCH;
      end

      S_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          w_instr_load = 1'b1;
          w_state_nxt  = S_DECODE;
        end else if (w_tmo_hit) begin
          w_trap_cause_nxt = 2'b10;
          w_state_nxt      = S_TRAP;
        end else begin
          w_tmo_cnt_nxt = w_tmo_inc;
        end
      end

      S_DECODE: begin
        if (w_legal) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_trap_cause_nxt = 2'b01;
          w_state_nxt      = S_TRAP;
        end
      end

      S_EXEC: begin
        if (bus.dec_read_mem || bus.dec_write_mem) begin
          // Latch the direction so dmem_we stays stable for the whole access.
          w_dmem_we_nxt = bus.dec_write_mem;
          w_tmo_cnt_nxt = 32'd0;
          w_state_nxt   = S_MEM;
        end else begin
          w_state_nxt = S_WB;
        end
      end

      S_MEM: begin
        bus.dmem_req = 1'b1;
        bus.dmem_we  = r_dmem_we;
        if (bus.dmem_ack) begin
          w_state_nxt = S_WB;
        end else if (w_tmo_hit) begin
          w_trap_cause_nxt = 2'b11;
          w_state_nxt      = S_TRAP;
        end else begin
          w_tmo_cnt_nxt = w_tmo_inc;
        end
      end

      S_WB: begin
        bus.pc_we = 1'b1;
        if (bus.dec_jump)                           bus.pc_sel = 2'b10;
        else if (bus.dec_branch && bus.branch_taken) bus.pc_sel = 2'b01;
        else                                        bus.pc_sel = 2'b00;
        // Writes to x0 are suppressed here so the register file needs no guard.
        bus.reg_we = bus.dec_write_reg && (r_instr[11:7] != 5'd0);
        if (bus.dec_jump)          bus.wb_sel = 2'b10;
        else if (bus.dec_read_mem) bus.wb_sel = 2'b01;
        else                       bus.wb_sel = 2'b00;
        w_tmo_cnt_nxt = 32'd0;
        w_state_nxt   = S_FETCH;
      end

      S_TRAP: begin
        bus.trap = 1'b1;
      end

      default: begin
        w_state_nxt = S_TRAP;
      end
    endcase
  end

  assign bus.instr      = r_instr;
  assign bus.trap_cause = r_trap_cause;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_INIT;
      r_instr      <= INSTR_NOP;
      r_tmo_cnt    <= 32'd0;
      r_dmem_we    <= 1'b0;
      r_trap_cause <= 2'b00;
    end else begin
      r_state      <= w_state_nxt;
      r_tmo_cnt    <= w_tmo_cnt_nxt;
      r_dmem_we    <= w_dmem_we_nxt;
      r_trap_cause <= w_trap_cause_nxt;
      if (w_instr_load) r_instr <= bus.imem_rdata;
    end
  end

`ifdef SEQ_PERF_COUNTERS_EN
  logic [63:0] r_cycle_count;
  logic [63:0] r_instret_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_count   <= 64'd0;
      r_instret_count <= 64'd0;
    end else begin
      if (r_state != S_TRAP) r_cycle_count   <= r_cycle_count + 64'd1;
      if (r_state == S_WB)   r_instret_count <= r_instret_count + 64'd1;
    end
  end

  assign bus.cycle_count   = r_cycle_count;
  assign bus.instret_count = r_instret_count;
`else
  assign bus.cycle_count   = 64'd0;
  assign bus.instret_count = 64'd0;
`endif

endmodule
